// File: rtl/noc_arb_mux_if.sv
// Handshake bundle for noc_arb_mux: NUM_IN source channels in, one registered channel out.
// The arbiter takes the slave modport; the traffic source/sink takes master.
interface noc_arb_mux_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_src;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_src
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );
endinterface

// File: rtl/noc_arb_mux.sv
// N-input valid/ready arbitrating mux with round-robin or static source selection,
// feeding a single-entry output register with full back-pressure.
module noc_arb_mux #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic             clk,
   input  logic             reset,
   noc_arb_mux_if.slave     bus,
   input  logic             cfg_mode,
   input  logic [SEL_W-1:0] cfg_sel
);

   logic [WIDTH-1:0]    r_out_data;
   logic [SEL_W-1:0]    r_out_src;
   logic                r_out_valid;
   logic [SEL_W-1:0]    r_ptr;

   logic                w_accept;
   logic                w_grant;
   logic                w_xfer;
   logic [SEL_W-1:0]    w_win;
   logic [SEL_W:0]      w_sum;
   logic [2*NUM_IN-1:0] w_req2;
   logic [NUM_IN-1:0]   w_rot;
   logic [WIDTH-1:0]    w_data;
   logic [NUM_IN-1:0]   w_in_ready;

   assign w_accept = !r_out_valid || bus.out_ready;
   assign w_req2   = {bus.in_valid, bus.in_valid};

   // Rotating the doubled request vector by ptr puts the scan start at bit 0.
   always_comb begin
      w_grant = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_rot   = NUM_IN'(w_req2 >> r_ptr);
      if (cfg_mode) begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!w_grant && cfg_sel == SEL_W'(i) && bus.in_valid[i]) begin
               w_grant = 1'b1;
               w_win   = SEL_W'(i);
            end
         end
      end else begin
         for (int unsigned j = 0; j < NUM_IN; j++) begin
            if (!w_grant && w_rot[j]) begin
               w_grant = 1'b1;
               w_sum   = {1'b0, r_ptr} + (SEL_W+1)'(j);
               if (w_sum >= (SEL_W+1)'(NUM_IN))
                  w_sum = w_sum - (SEL_W+1)'(NUM_IN);
               w_win   = w_sum[SEL_W-1:0];
            end
         end
      end
   end

   assign w_xfer = w_accept && w_grant && !reset;

   always_comb begin
      w_data     = '0;
      w_in_ready = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (w_win == SEL_W'(i)) begin
            w_data        = bus.in_data[i*WIDTH +: WIDTH];
            w_in_ready[i] = w_xfer;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_src   <= w_win;
         if (!cfg_mode)
            r_ptr <= (w_win == SEL_W'(NUM_IN-1)) ? '0 : w_win + SEL_W'(1);
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_noc_arb_mux.sv
// Directed bench for noc_arb_mux: a reference arbiter predicts each grant and queues
// the expected word, which is popped and compared when the output register loads.
module tb_noc_arb_mux;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_mode;
   logic [1:0] cfg_sel;
   logic       cfg_mode3;
   logic [1:0] cfg_sel3;

   always #5 clk = ~clk;

   noc_arb_mux_if #(.WIDTH(16), .NUM_IN(4)) bus ();
   noc_arb_mux_if #(.WIDTH(16), .NUM_IN(3)) bus3 ();

   noc_arb_mux #(.WIDTH(16), .NUM_IN(4)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .cfg_mode(cfg_mode), .cfg_sel(cfg_sel)
   );

   noc_arb_mux #(.WIDTH(16), .NUM_IN(3)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3.slave), .cfg_mode(cfg_mode3), .cfg_sel(cfg_sel3)
   );

   typedef struct packed {
      logic [1:0]  src;
      logic [15:0] data;
   } sb_t;

   sb_t         sb[$];
   int unsigned mptr;
   bit          mv;
   logic [15:0] md;
   logic [1:0]  ms;
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mptr = 0;
      mv   = 1'b0;
      md   = '0;
      ms   = '0;
      sb.delete();
   endtask

   task automatic set_data();
      for (int i = 0; i < 4; i++) bus.in_data[i*16 +: 16] = 16'hA000 + 16'(i);
   endtask

   // Called at posedge+1; predicts the grant at the next negedge, checks the load after the edge.
   task automatic cycle();
      bit         acc, g, xfer;
      int         win;
      logic [3:0] er;
      sb_t        e;
      @(negedge clk);
      acc = !mv || bus.out_ready;
      g   = 1'b0;
      win = 0;
      if (!cfg_mode) begin
         for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (int'(mptr) + k) % 4;
            if (!g && bus.in_valid[idx]) begin
               g   = 1'b1;
               win = idx;
            end
         end
      end else if (bus.in_valid[cfg_sel]) begin
         g   = 1'b1;
         win = int'(cfg_sel);
      end
      xfer = acc && g;
      er   = xfer ? (4'b0001 << win) : 4'b0000;
      chk("in_ready", 32'(bus.in_ready), 32'(er));
      if (xfer) begin
         sb.push_back('{src: 2'(win), data: bus.in_data[win*16 +: 16]});
         if (!cfg_mode) mptr = (win + 1) % 4;
      end
      @(posedge clk);
      #1;
      if (xfer) begin
         e  = sb.pop_front();
         md = e.data;
         ms = e.src;
         mv = 1'b1;
      end else if (mv && bus.out_ready) begin
         mv = 1'b0;
      end
      chk("out_valid", 32'(bus.out_valid), 32'(mv));
      chk("out_data", 32'(bus.out_data), 32'(md));
      chk("out_src", 32'(bus.out_src), 32'(ms));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset         = 1'b1;
      cfg_mode      = 1'b0;
      cfg_sel       = 2'd0;
      bus.in_valid  = 4'hF;
      bus.out_ready = 1'b1;
      set_data();
      cfg_mode3      = 1'b0;
      cfg_sel3       = 2'd0;
      bus3.in_valid  = 3'b000;
      bus3.in_data   = '0;
      bus3.out_ready = 1'b1;
      model_reset();

      // Reset held with all inputs valid
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
         chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
         chk("rst_out_data", 32'(bus.out_data), 32'h0);
         chk("rst_out_src", 32'(bus.out_src), 32'h0);
      end
      reset = 1'b0;

      // Round-robin fairness, first grant after release is channel 0
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("rr_seq_src", 32'(bus.out_src), 32'(i % 4));
         chk("rr_seq_data", 32'(bus.out_data), 32'(16'hA000 + 16'(i % 4)));
      end

      // Sparse round-robin with wrap from ptr=0
      do_reset();
      bus.in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("sparse_src", 32'(bus.out_src), (i % 2 == 0) ? 32'd1 : 32'd3);
      end
      bus.in_valid = 4'b0010;
      repeat (3) begin
         cycle();
         chk("sparse_single", 32'(bus.out_src), 32'd1);
      end

      // Back-pressure on a held 16'h1234 word
      bus.in_valid = 4'b0001;
      bus.in_data[15:0] = 16'h1234;
      cycle();
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'hF;
      bus.in_data[15:0] = 16'hBEEF;
      repeat (5) begin
         cycle();
         chk("bp_hold", 32'(bus.out_data), 32'h1234);
      end
      bus.out_ready = 1'b1;
      set_data();
      cycle();
      chk("bp_no_bubble_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_no_bubble_src", 32'(bus.out_src), 32'd1);
      cycle();
      chk("rr_after_bp", 32'(bus.out_src), 32'd2);

      // Static selection leaves the round-robin pointer alone
      cfg_mode = 1'b1;
      cfg_sel  = 2'd2;
      repeat (4) begin
         cycle();
         chk("static_src", 32'(bus.out_src), 32'd2);
      end
      cfg_mode = 1'b0;
      cycle();
      chk("ptr_kept", 32'(bus.out_src), 32'd3);

      // Out-of-range static index on the 3-input instance; main instance idles meanwhile
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b0000;
      for (int i = 0; i < 3; i++) bus3.in_data[i*16 +: 16] = 16'hC000 + 16'(i);
      bus3.in_valid = 3'b111;
      cfg_mode3     = 1'b1;
      cfg_sel3      = 2'd2;
      @(negedge clk);
      chk("s3_in_ready", 32'(bus3.in_ready), 32'b100);
      @(posedge clk);
      #1;
      chk("s3_out_valid", 32'(bus3.out_valid), 32'd1);
      chk("s3_out_data", 32'(bus3.out_data), 32'hC002);
      cfg_sel3 = 2'd3;
      repeat (2) begin
         @(negedge clk);
         chk("oor_in_ready", 32'(bus3.in_ready), 32'h0);
         @(posedge clk);
         #1;
         chk("oor_drained", 32'(bus3.out_valid), 32'd0);
      end
      bus3.in_valid = 3'b000;

      // Reset mid-stream while stalled with a word held
      bus.in_valid = 4'hF;
      cycle();
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_data", 32'(bus.out_data), 32'h0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready2", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("mid_rst_valid2", 32'(bus.out_valid), 32'd0);
      reset = 1'b0;
      model_reset();
      cycle();
      chk("post_rst_src", 32'(bus.out_src), 32'd0);
      chk("post_rst_data", 32'(bus.out_data), 32'hA000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
